// File: rtl/sdio_reg_bank.sv
// sdio_reg_bank
//   Multi-channel SDIO register file. NUM_CH identical byte-wide register
//   windows share one request/acknowledge bus. Each window holds the command
//   and data setup registers, sticky write-1-to-clear interrupt and error
//   status with enables, and a per-channel registered interrupt. Wide fields
//   (block_size, block_count, cmd_argument) are written low bytes first into
//   shadow bytes and committed atomically by the write of the top byte.
//
// Ports
//   sys_clk, rst               clock, synchronous active-high reset
//   reg_req/reg_wr/reg_addr/reg_wdata   bus access (one cycle per access)
//   reg_rdata/reg_ack          access completion, one cycle after reg_req
//   block_size, block_count, cmd_argument, cmd_ctrl, cmd_index
//                              per-channel setup fields, channel k in slice k
//   cmd_start, ch_rst          one-cycle pulses per channel
//   irq_evt, err_evt           per-channel event pulses from the engines
//   cmd_busy, dat_busy         per-channel engine busy flags
//   irq                        per-channel registered interrupt
//
// Bus handshake: every cycle with reg_req=1 (and rst=0) is one complete
// access; reg_ack follows exactly one cycle later with reg_rdata, which is
// the read value for reads and 0 for writes. reg_rdata is 0 whenever
// reg_ack is 0. There is no back-pressure; requests may arrive every cycle.

module sdio_reg_bank #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 8,
    parameter int CH_STRIDE = 16,
    parameter int IRQ_W     = 5,
    parameter int ERR_W     = 7
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    reg_req,
    input  logic                    reg_wr,
    input  logic [ADDR_W-1:0]       reg_addr,
    input  logic [7:0]              reg_wdata,
    output logic [7:0]              reg_rdata,
    output logic                    reg_ack,
    output logic [NUM_CH*16-1:0]    block_size,
    output logic [NUM_CH*16-1:0]    block_count,
    output logic [NUM_CH*32-1:0]    cmd_argument,
    output logic [NUM_CH*7-1:0]     cmd_ctrl,
    output logic [NUM_CH*6-1:0]     cmd_index,
    output logic [NUM_CH-1:0]       cmd_start,
    output logic [NUM_CH-1:0]       ch_rst,
    input  logic [NUM_CH*IRQ_W-1:0] irq_evt,
    input  logic [NUM_CH*ERR_W-1:0] err_evt,
    input  logic [NUM_CH-1:0]       cmd_busy,
    input  logic [NUM_CH-1:0]       dat_busy,
    output logic [NUM_CH-1:0]       irq
);

    localparam int OFF_W = $clog2(CH_STRIDE);

    // Shadow byte slots: 0 = block_size lo, 1 = block_count lo,
    // 2..4 = cmd_argument bytes 0..2.
    logic [15:0]      blk_size_q   [NUM_CH];
    logic [15:0]      blk_size_d   [NUM_CH];
    logic [15:0]      blk_count_q  [NUM_CH];
    logic [15:0]      blk_count_d  [NUM_CH];
    logic [31:0]      cmd_arg_q    [NUM_CH];
    logic [31:0]      cmd_arg_d    [NUM_CH];
    logic [6:0]       cmd_ctrl_q   [NUM_CH];
    logic [6:0]       cmd_ctrl_d   [NUM_CH];
    logic [5:0]       cmd_idx_q    [NUM_CH];
    logic [5:0]       cmd_idx_d    [NUM_CH];
    logic [IRQ_W-1:0] irq_status_q [NUM_CH];
    logic [IRQ_W-1:0] irq_status_d [NUM_CH];
    logic [ERR_W-1:0] err_status_q [NUM_CH];
    logic [ERR_W-1:0] err_status_d [NUM_CH];
    logic [IRQ_W-1:0] irq_en_q     [NUM_CH];
    logic [IRQ_W-1:0] irq_en_d     [NUM_CH];
    logic [ERR_W-1:0] err_en_q     [NUM_CH];
    logic [ERR_W-1:0] err_en_d     [NUM_CH];
    logic [4:0][7:0]  shadow_q     [NUM_CH];
    logic [4:0][7:0]  shadow_d     [NUM_CH];

    logic [NUM_CH-1:0] cmd_start_q, cmd_start_d;
    logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
    logic [NUM_CH-1:0] irq_q, irq_d;
    logic              ack_q, ack_d;
    logic [7:0]        rdata_q, rdata_d;

    logic [ADDR_W-1:0] ch_full;
    logic [ADDR_W-1:0] off_full;
    logic [3:0]        off4;
    logic              mapped;

    // Channel/offset split; offsets past 15 in a wider stride are unmapped.
    // A channel index >= NUM_CH simply matches no window below.
    always_comb begin
        ch_full  = reg_addr >> OFF_W;
        off_full = reg_addr & ADDR_W'(CH_STRIDE - 1);
        off4     = off_full[3:0];
        mapped   = (off_full < ADDR_W'(16));
    end

    always_comb begin
        logic             wr_k;
        logic             busy_err;
        logic [IRQ_W-1:0] irq_clr;
        logic [ERR_W-1:0] err_clr;
        logic [ERR_W-1:0] err_busy_v;

        cmd_start_d = '0;
        ch_rst_d    = '0;
        irq_d       = '0;
        rdata_d     = 8'h00;
        ack_d       = reg_req;
        wr_k        = 1'b0;
        busy_err    = 1'b0;
        irq_clr     = '0;
        err_clr     = '0;
        err_busy_v  = '0;

        for (int k = 0; k < NUM_CH; k++) begin
            blk_size_d[k]  = blk_size_q[k];
            blk_count_d[k] = blk_count_q[k];
            cmd_arg_d[k]   = cmd_arg_q[k];
            cmd_ctrl_d[k]  = cmd_ctrl_q[k];
            cmd_idx_d[k]   = cmd_idx_q[k];
            irq_en_d[k]    = irq_en_q[k];
            err_en_d[k]    = err_en_q[k];
            shadow_d[k]    = shadow_q[k];
            irq_clr        = '0;
            err_clr        = '0;
            busy_err       = 1'b0;

            wr_k = reg_req & reg_wr & mapped & (ch_full == ADDR_W'(k));
            if (wr_k) begin
                case (off4)
                    4'd0:  shadow_d[k][0] = reg_wdata;
                    4'd1:  blk_size_d[k]  = {reg_wdata, shadow_q[k][0]};
                    4'd2:  shadow_d[k][1] = reg_wdata;
                    4'd3:  blk_count_d[k] = {reg_wdata, shadow_q[k][1]};
                    4'd4:  shadow_d[k][2] = reg_wdata;
                    4'd5:  shadow_d[k][3] = reg_wdata;
                    4'd6:  shadow_d[k][4] = reg_wdata;
                    4'd7:  cmd_arg_d[k]   = {reg_wdata, shadow_q[k][4],
                                             shadow_q[k][3], shadow_q[k][2]};
                    4'd8:  cmd_ctrl_d[k]  = reg_wdata[6:0];
                    4'd9: begin
                        // The index always updates; only the start is
                        // refused (and flagged) while the engine is busy.
                        cmd_idx_d[k] = reg_wdata[5:0];
                        if (cmd_busy[k]) busy_err = 1'b1;
                        else             cmd_start_d[k] = 1'b1;
                    end
                    4'd10: irq_clr     = reg_wdata[IRQ_W-1:0];
                    4'd11: err_clr     = reg_wdata[ERR_W-1:0];
                    4'd12: irq_en_d[k] = reg_wdata[IRQ_W-1:0];
                    4'd13: err_en_d[k] = reg_wdata[ERR_W-1:0];
                    4'd15: ch_rst_d[k] = reg_wdata[0];
                    default: ;
                endcase
            end

            // Status: clears (w1c or soft reset) apply first, then this
            // cycle's events are OR-ed in so a set always wins.
            err_busy_v          = '0;
            err_busy_v[ERR_W-1] = busy_err;
            if (ch_rst_d[k]) begin
                shadow_d[k]     = '0;
                irq_status_d[k] = irq_evt[k*IRQ_W +: IRQ_W];
                err_status_d[k] = err_evt[k*ERR_W +: ERR_W] | err_busy_v;
            end else begin
                irq_status_d[k] = (irq_status_q[k] & ~irq_clr)
                                | irq_evt[k*IRQ_W +: IRQ_W];
                err_status_d[k] = (err_status_q[k] & ~err_clr)
                                | err_evt[k*ERR_W +: ERR_W] | err_busy_v;
            end

            irq_d[k] = (|(irq_status_q[k] & irq_en_q[k]))
                     | (|(err_status_q[k] & err_en_q[k]));

            // Reads always see committed values, never the shadows.
            if (reg_req && !reg_wr && mapped && (ch_full == ADDR_W'(k))) begin
                case (off4)
                    4'd0:  rdata_d = blk_size_q[k][7:0];
                    4'd1:  rdata_d = blk_size_q[k][15:8];
                    4'd2:  rdata_d = blk_count_q[k][7:0];
                    4'd3:  rdata_d = blk_count_q[k][15:8];
                    4'd4:  rdata_d = cmd_arg_q[k][7:0];
                    4'd5:  rdata_d = cmd_arg_q[k][15:8];
                    4'd6:  rdata_d = cmd_arg_q[k][23:16];
                    4'd7:  rdata_d = cmd_arg_q[k][31:24];
                    4'd8:  rdata_d = {1'b0, cmd_ctrl_q[k]};
                    4'd9:  rdata_d = {2'b00, cmd_idx_q[k]};
                    4'd10: rdata_d = 8'(irq_status_q[k]);
                    4'd11: rdata_d = 8'(err_status_q[k]);
                    4'd12: rdata_d = 8'(irq_en_q[k]);
                    4'd13: rdata_d = 8'(err_en_q[k]);
                    4'd14: rdata_d = {6'b0, dat_busy[k], cmd_busy[k]};
                    default: rdata_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                blk_size_q[k]   <= '0;
                blk_count_q[k]  <= '0;
                cmd_arg_q[k]    <= '0;
                cmd_ctrl_q[k]   <= '0;
                cmd_idx_q[k]    <= '0;
                irq_status_q[k] <= '0;
                err_status_q[k] <= '0;
                irq_en_q[k]     <= '0;
                err_en_q[k]     <= '0;
                shadow_q[k]     <= '0;
            end
            cmd_start_q <= '0;
            ch_rst_q    <= '0;
            irq_q       <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                blk_size_q[k]   <= blk_size_d[k];
                blk_count_q[k]  <= blk_count_d[k];
                cmd_arg_q[k]    <= cmd_arg_d[k];
                cmd_ctrl_q[k]   <= cmd_ctrl_d[k];
                cmd_idx_q[k]    <= cmd_idx_d[k];
                irq_status_q[k] <= irq_status_d[k];
                err_status_q[k] <= err_status_d[k];
                irq_en_q[k]     <= irq_en_d[k];
                err_en_q[k]     <= err_en_d[k];
                shadow_q[k]     <= shadow_d[k];
            end
            cmd_start_q <= cmd_start_d;
            ch_rst_q    <= ch_rst_d;
            irq_q       <= irq_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign block_size[g*16 +: 16]   = blk_size_q[g];
        assign block_count[g*16 +: 16]  = blk_count_q[g];
        assign cmd_argument[g*32 +: 32] = cmd_arg_q[g];
        assign cmd_ctrl[g*7 +: 7]       = cmd_ctrl_q[g];
        assign cmd_index[g*6 +: 6]      = cmd_idx_q[g];
    end

    assign cmd_start = cmd_start_q;
    assign ch_rst    = ch_rst_q;
    assign irq       = irq_q;
    assign reg_ack   = ack_q;
    assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_sdio_reg_bank.sv
module tb_sdio_reg_bank;

    localparam int NUM_CH = 2;
    localparam int IRQ_W  = 5;
    localparam int ERR_W  = 7;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    reg_req = 1'b0;
    logic                    reg_wr = 1'b0;
    logic [7:0]              reg_addr = 8'h00;
    logic [7:0]              reg_wdata = 8'h00;
    logic [7:0]              reg_rdata;
    logic                    reg_ack;
    logic [NUM_CH*16-1:0]    block_size;
    logic [NUM_CH*16-1:0]    block_count;
    logic [NUM_CH*32-1:0]    cmd_argument;
    logic [NUM_CH*7-1:0]     cmd_ctrl;
    logic [NUM_CH*6-1:0]     cmd_index;
    logic [NUM_CH-1:0]       cmd_start;
    logic [NUM_CH-1:0]       ch_rst;
    logic [NUM_CH*IRQ_W-1:0] irq_evt = '0;
    logic [NUM_CH*ERR_W-1:0] err_evt = '0;
    logic [NUM_CH-1:0]       cmd_busy = '0;
    logic [NUM_CH-1:0]       dat_busy = '0;
    logic [NUM_CH-1:0]       irq;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    sdio_reg_bank #(
        .NUM_CH(NUM_CH), .ADDR_W(8), .CH_STRIDE(16), .IRQ_W(IRQ_W), .ERR_W(ERR_W)
    ) dut (
        .sys_clk(clk), .rst(rst), .reg_req(reg_req), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .reg_ack(reg_ack), .block_size(block_size), .block_count(block_count),
        .cmd_argument(cmd_argument), .cmd_ctrl(cmd_ctrl), .cmd_index(cmd_index),
        .cmd_start(cmd_start), .ch_rst(ch_rst), .irq_evt(irq_evt),
        .err_evt(err_evt), .cmd_busy(cmd_busy), .dat_busy(dat_busy), .irq(irq)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every ack pops one expected rdata; rdata must be 0 otherwise
    always @(negedge clk) begin
        if (reg_ack === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: got ack rdata=%02h want no ack", reg_rdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (reg_rdata !== e) begin
                    bad++;
                    $display("FAIL rdata: got %02h want %02h", reg_rdata, e);
                end
            end
        end else if (!rst) begin
            total++;
            if (reg_rdata !== 8'h00 || reg_ack !== 1'b0) begin
                bad++;
                $display("FAIL idle_bus: got ack=%b rdata=%02h want 0/00", reg_ack, reg_rdata);
            end
        end
    end

    // Driver tasks
    task automatic access(input logic wr, input logic [7:0] addr,
                          input logic [7:0] data, input logic [7:0] exp);
        @(posedge clk); #1;
        reg_req = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = data;
        exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reg_req = 1'b0; reg_wr = 1'b0; reg_wdata = 8'h00;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_block_size", 64'(block_size), 64'h0);
        check("rst_cmd_argument", cmd_argument, 64'h0);
        check("rst_pulses", 64'({cmd_start, ch_rst, irq}), 64'h0);
        check("rst_ack", 64'(reg_ack), 64'h0);
        access(0, 8'h18, 8'h00, 8'h00);
        idle(1);

        // Atomic cmd_argument commit on ch0
        access(1, 8'h04, 8'h11, 8'h00);
        access(1, 8'h05, 8'h22, 8'h00);
        access(1, 8'h06, 8'h33, 8'h00);
        idle(1);
        check("arg_shadow_only", 64'(cmd_argument[31:0]), 64'h0);
        access(1, 8'h07, 8'h44, 8'h00);
        idle(1);
        check("arg_commit", 64'(cmd_argument[31:0]), 64'h44332211);
        access(0, 8'h04, 8'h00, 8'h11);
        access(0, 8'h07, 8'h00, 8'h44);
        access(1, 8'h07, 8'h55, 8'h00);
        idle(1);
        check("arg_held_shadow", 64'(cmd_argument[31:0]), 64'h55332211);

        // block_size ch1
        access(1, 8'h10, 8'h34, 8'h00);
        access(1, 8'h11, 8'h12, 8'h00);
        idle(1);
        check("block_size_ch1", 64'(block_size), 64'h1234_0000);
        access(0, 8'h10, 8'h00, 8'h34);
        access(0, 8'h11, 8'h00, 8'h12);

        // cmd_start, then start-while-busy
        access(1, 8'h09, 8'h11, 8'h00);
        idle(1);
        check("cmd_start_pulse", 64'(cmd_start), 64'h1);
        check("cmd_index_0", 64'(cmd_index), 64'h011);
        idle(1);
        check("cmd_start_one_cycle", 64'(cmd_start), 64'h0);
        cmd_busy = 2'b01;
        access(1, 8'h09, 8'h22, 8'h00);
        idle(1);
        check("cmd_start_busy", 64'(cmd_start), 64'h0);
        check("cmd_index_busy", 64'(cmd_index), 64'h022);
        cmd_busy = 2'b00;
        access(0, 8'h0B, 8'h00, 8'h40);

        // Interrupt path on ch1
        access(1, 8'h1C, 8'h01, 8'h00);
        idle(1);
        irq_evt[IRQ_W] = 1'b1;
        idle(1);
        irq_evt = '0;
        check("irq_not_yet", 64'(irq), 64'h0);
        idle(1);
        check("irq_set", 64'(irq), 64'h2);
        access(1, 8'h1A, 8'h01, 8'h00);
        irq_evt[IRQ_W] = 1'b1;
        idle(1);
        irq_evt = '0;
        idle(1);
        check("irq_set_wins", 64'(irq), 64'h2);
        access(0, 8'h1A, 8'h00, 8'h01);
        access(1, 8'h1A, 8'h01, 8'h00);
        idle(1);
        check("irq_clear_lag", 64'(irq), 64'h2);
        idle(1);
        check("irq_cleared", 64'(irq), 64'h0);

        // Error event on ch0 plus w1c of a single bit
        err_evt[2] = 1'b1;
        idle(1);
        err_evt = '0;
        access(0, 8'h0B, 8'h00, 8'h44);
        access(1, 8'h0B, 8'h04, 8'h00);
        access(0, 8'h0B, 8'h00, 8'h40);

        // Soft reset ch0: status and shadows clear, setup kept
        access(1, 8'h0F, 8'h01, 8'h00);
        idle(1);
        check("ch_rst_pulse", 64'(ch_rst), 64'h1);
        idle(1);
        check("ch_rst_one_cycle", 64'(ch_rst), 64'h0);
        check("ch_rst_keeps_index", 64'(cmd_index), 64'h022);
        access(0, 8'h0B, 8'h00, 8'h00);
        access(0, 8'h0F, 8'h00, 8'h00);
        access(1, 8'h07, 8'h66, 8'h00);
        idle(1);
        check("ch_rst_shadow_cleared", 64'(cmd_argument[31:0]), 64'h66000000);

        // Unmapped channel and busy readback
        access(1, 8'h20, 8'hFF, 8'h00);
        idle(1);
        check("unmapped_block_size", 64'(block_size), 64'h1234_0000);
        check("unmapped_cmd_arg", cmd_argument, 64'h0000_0000_6600_0000);
        check("unmapped_ctrl_idx", 64'({cmd_ctrl, cmd_index}), 64'h022);
        access(0, 8'h20, 8'h00, 8'h00);
        dat_busy = 2'b01;
        cmd_busy = 2'b10;
        access(0, 8'h0E, 8'h00, 8'h02);
        access(0, 8'h1E, 8'h00, 8'h01);
        idle(1);
        dat_busy = '0;
        cmd_busy = '0;

        // Back-to-back write/read burst, with reset mid-burst
        access(1, 8'h0C, 8'h03, 8'h00);
        access(0, 8'h0C, 8'h00, 8'h03);
        access(1, 8'h0C, 8'hFF, 8'h00);
        access(0, 8'h0C, 8'h00, 8'h1F);
        access(1, 8'h0C, 8'h05, 8'h00);
        access(0, 8'h0C, 8'h00, 8'h05);
        @(posedge clk); #1;
        rst = 1'b1; reg_req = 1'b1; reg_wr = 1'b1; reg_addr = 8'h0C; reg_wdata = 8'hAA;
        @(posedge clk); #1;
        rst = 1'b0; reg_req = 1'b0; reg_wr = 1'b0;
        check("ack_dropped_on_rst", 64'(reg_ack), 64'h0);
        check("rst_block_size_2", 64'(block_size), 64'h0);
        access(0, 8'h0C, 8'h00, 8'h00);
        access(0, 8'h07, 8'h00, 8'h00);
        access(0, 8'h11, 8'h00, 8'h00);
        access(0, 8'h19, 8'h00, 8'h00);
        idle(3);

        check("all_acks_seen", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdio_reg_bank.md
Name: sdio_reg_bank

Overview:
Parametrised, multi-channel successor to the single-channel SDIO register file. It provides NUM_CH identical per-channel register windows on one byte-wide request/acknowledge bus. Each window holds command/data setup registers, sticky interrupt and error status with write-1-to-clear, per-channel interrupt outputs, and atomic multi-byte commit of wide fields through shadow bytes. It sits between the host bus bridge and the NUM_CH cmd/dat engines, all in the sys_clk domain.

Parameters:
NUM_CH, 2, number of channel windows (1..8)
ADDR_W, 8, bus address width
CH_STRIDE, 16, bytes per channel window (power of 2, >=16); channel = addr / CH_STRIDE, offset = addr % CH_STRIDE
IRQ_W, 5, interrupt event bits per channel (<=8)
ERR_W, 7, error event bits per channel (<=8)

Ports:
sys_clk  in  1  clock
rst  in  1  synchronous active-high reset
reg_req  in  1  bus access strobe, one cycle per access
reg_wr  in  1  1 = write, 0 = read; qualified by reg_req
reg_addr  in  ADDR_W  byte address
reg_wdata  in  8  write data
reg_rdata  out  8  read data, valid while reg_ack=1
reg_ack  out  1  access completion pulse
block_size  out  NUM_CH*16  per-channel block size; ch k in [16k+15:16k]
block_count  out  NUM_CH*16  per-channel block count
cmd_argument  out  NUM_CH*32  per-channel command argument
cmd_ctrl  out  NUM_CH*7  {dat_trans_width, dat_trans_dir, dat_present, cmd_index_check, cmd_crc_check, resp_type[1:0]}
cmd_index  out  NUM_CH*6  command index
cmd_start  out  NUM_CH  one-cycle start pulse per channel
ch_rst  out  NUM_CH  one-cycle soft reset pulse per channel
irq_evt  in  NUM_CH*IRQ_W  event pulses from the engines; level sampled each cycle
err_evt  in  NUM_CH*ERR_W  error pulses
cmd_busy  in  NUM_CH  engine busy
dat_busy  in  NUM_CH  engine busy
irq  out  NUM_CH  registered per-channel interrupt

Behaviour:
- Reset (rst=1 at a sys_clk edge): all registers, shadows, status and enables go to 0. reg_ack, reg_rdata, cmd_start, ch_rst and irq go to 0. An access whose req coincides with rst is dropped and gets no ack.
- Handshake: reg_ack equals reg_req delayed by 1 cycle. reg_rdata is registered in the req cycle and presented with ack. It is 0 on writes and on non-ack cycles. Back-to-back req every cycle is legal; each access gets its own ack.
- Write timing: a write in cycle n updates the target at the n/n+1 edge and is visible on the outputs and on a read from cycle n+1.
- Address decode: channel >= NUM_CH, or an unmapped offset, means the write is ignored and the read returns 0; ack is still returned.
- Offset map:
  - 0/1 block_size lo/hi
  - 2/3 block_count lo/hi
  - 4..7 cmd_argument bytes 0..3
  - 8 cmd_ctrl [6:0]
  - 9 cmd_index [5:0]
  - 10 irq_status
  - 11 err_status
  - 12 irq_en
  - 13 err_en
  - 14 RO {6'b0, dat_busy, cmd_busy}
  - 15 control: bit0 = ch_rst, write-only, reads 0
- Atomic commit: writes to offsets 0, 2 and 4..6 load per-channel shadow bytes only. Writing offset 1 commits {wdata, shadow0} to block_size. Offset 3 commits block_count the same way. Offset 7 commits {wdata, shadow6, shadow5, shadow4} to cmd_argument. Reads of offsets 0..7 return committed values, never shadows. A commit with no fresh low writes uses the held shadow contents.
- cmd_start[k]: high exactly one cycle, the cycle after a write to offset 9 of channel k, if cmd_busy[k]=0 in the write cycle. If cmd_busy[k]=1, cmd_index still updates, no pulse is issued, and err_status bit ERR_W-1 (start-while-busy) is set.
- Status (offsets 10/11), per bit, each cycle:
  - set if the event bit is 1
  - else cleared if a write to that offset has that wdata bit 1
  - else held
  - Set wins over a simultaneous clear.
  - Bits >= IRQ_W / ERR_W read 0.
- ch_rst[k]: a write of bit0=1 to offset 15 pulses ch_rst[k] the next cycle. On the same edge it clears channel k's irq_status, err_status and shadows. Setup registers and enables are kept.
- irq[k] is registered: |(irq_status & irq_en) | |(err_status & err_en). It deasserts 1 cycle after the last enabled bit clears or is masked.

Test Plan:
- Reset then read ch1 offset 8 (addr 0x18) -> ack 1 cycle after req, rdata 0x00. All outputs 0.
- Write ch0 0x04=0x11, 0x05=0x22, 0x06=0x33 -> cmd_argument[31:0] stays 0. Then write 0x07=0x44 -> cmd_argument[31:0]=0x44332211 the next cycle, in a single step.
- Write ch1 0x1C=0x01 (irq_en bit0), pulse irq_evt[IRQ_W]=1 -> irq[1]=1 two cycles after the event. Write 0x1A=0x01 in the same cycle as another event pulse -> bit stays 1. Write 0x1A=0x01 alone -> irq[1]=0 two cycles later.
- Write ch0 0x09=0x11 with cmd_busy[0]=0 -> cmd_start[0] pulses for 1 cycle. Repeat with cmd_busy[0]=1 -> no pulse, err_status[ERR_W-1]=1.
- With NUM_CH=2: write 0x20=0xFF -> no output changes. Read 0x20 -> ack with rdata 0x00.
- Req every cycle alternating write/read to 0x0C/0x0C -> one ack per req. The read returns the value written the prior cycle. Assert rst mid-burst -> ack drops the next cycle and all registers read 0.
